bfsh_host_ctrl: RTL

//  Synthesizable initiator for BFSH_Core: loads the 64-bit key, waits out key-schedule init,

---
 rtl/bfsh_host_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/bfsh_host_ctrl.sv
// Host-side sequencer for the BFSH core: loads the key, waits out key-schedule init,
// then runs one block at a time from a valid/ready stream and hands back each result.
module bfsh_host_ctrl #(
    parameter int START_WAIT   = 4,
    parameter int INIT_TIMEOUT = 131072,
    parameter int BUSY_TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] key_in,
    input  logic        key_load,
    output logic        key_ready,
    input  logic        blk_valid,
    output logic        blk_ready,
    input  logic [63:0] blk_data,
    input  logic        blk_enc,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [63:0] res_data,
    output logic        res_enc,
    output logic        err,
    input  logic        err_clr,
    output logic        core_en_key,
    output logic [63:0] core_key,
    output logic        core_en_pt,
    output logic        core_en_enc_dec,
    output logic [63:0] core_pt,
    input  logic        core_initializing,
    input  logic        core_busy,
    input  logic [63:0] core_ct
);

    localparam int CNT_MAX_IB = (INIT_TIMEOUT > BUSY_TIMEOUT) ? INIT_TIMEOUT : BUSY_TIMEOUT;
    localparam int CNT_MAX    = (CNT_MAX_IB > START_WAIT) ? CNT_MAX_IB : START_WAIT;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_WAIT - 1);
    localparam logic [CNT_W-1:0] INIT_LIMIT = CNT_W'(INIT_TIMEOUT);
    localparam logic [CNT_W-1:0] BUSY_LIMIT = CNT_W'(BUSY_TIMEOUT);

    typedef enum logic [3:0] {
        NOKEY,
        KEY_ISSUE,
        KEY_START,
        KEY_WAIT,
        READY,
        BLK_ISSUE,
        BLK_START,
        BLK_WAIT,
        RESULT,
        ERROR
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               key_pending_reg;

    // A key request arriving in the same cycle as a block always takes precedence.
    assign key_ready = (state_reg == READY) && !key_pending_reg;
    assign blk_ready = key_ready && !key_load;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= NOKEY;
            cnt_reg         <= '0;
            key_pending_reg <= 1'b0;
            core_en_key     <= 1'b0;
            core_key        <= '0;
            core_en_pt      <= 1'b0;
            core_en_enc_dec <= 1'b0;
            core_pt         <= '0;
            res_valid       <= 1'b0;
            res_data        <= '0;
            res_enc         <= 1'b0;
            err             <= 1'b0;
        end else begin
            core_en_key <= 1'b0;
            core_en_pt  <= 1'b0;

            if (key_load && (state_reg != ERROR)) begin
                key_pending_reg <= 1'b1;
                core_key        <= key_in;
            end

            case (state_reg)
                NOKEY, READY: begin
                    if (key_pending_reg) begin
                        core_en_key <= 1'b1;
                        if (!key_load) key_pending_reg <= 1'b0;
                        state_reg <= KEY_ISSUE;
                        cnt_reg   <= '0;
                    end else if (blk_valid && blk_ready) begin
                        core_pt         <= blk_data;
                        core_en_enc_dec <= blk_enc;
                        core_en_pt      <= 1'b1;
                        state_reg       <= BLK_ISSUE;
                        cnt_reg         <= '0;
                    end
                end
                KEY_ISSUE: begin
                    state_reg <= KEY_START;
                    cnt_reg   <= '0;
                end
                KEY_START: begin
                    if (core_initializing) begin
                        state_reg <= KEY_WAIT;
                        cnt_reg   <= '0;
                    end else if (cnt_reg >= START_LAST) begin
                        state_reg       <= ERROR;
                        err             <= 1'b1;
                        key_pending_reg <= 1'b0;
                        cnt_reg         <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                KEY_WAIT: begin
                    if (!core_initializing) begin
                        state_reg <= READY;
                        cnt_reg   <= '0;
                    end else if (cnt_reg >= INIT_LIMIT) begin
                        state_reg       <= ERROR;
                        err             <= 1'b1;
                        key_pending_reg <= 1'b0;
                        cnt_reg         <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                BLK_ISSUE: begin
                    state_reg <= BLK_START;
                    cnt_reg   <= '0;
                end
                BLK_START: begin
                    if (core_busy) begin
                        state_reg <= BLK_WAIT;
                        cnt_reg   <= '0;
                    end else if (cnt_reg >= START_LAST) begin
                        state_reg       <= ERROR;
                        err             <= 1'b1;
                        key_pending_reg <= 1'b0;
                        cnt_reg         <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                BLK_WAIT: begin
                    // The core's ct is only trusted on the first cycle busy reads low.
                    if (!core_busy) begin
                        res_data  <= core_ct;
                        res_enc   <= core_en_enc_dec;
                        res_valid <= 1'b1;
                        state_reg <= RESULT;
                        cnt_reg   <= '0;
                    end else if (cnt_reg >= BUSY_LIMIT) begin
                        state_reg       <= ERROR;
                        err             <= 1'b1;
                        key_pending_reg <= 1'b0;
                        cnt_reg         <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state_reg <= READY;
                        cnt_reg   <= '0;
                    end
                end
                ERROR: begin
                    if (err_clr) begin
                        err       <= 1'b0;
                        state_reg <= NOKEY;
                        cnt_reg   <= '0;
                    end
                end
                default: begin
                    state_reg <= NOKEY;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

endmodule
